// File: rtl/matmul_seq_ctrl.sv
// Sequential DIM x DIM matrix multiply controller.
// One shared 4x4 multiplier, one accumulator, valid/ready on both sides.

module multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  // Shift-and-add array of partial products
  always_comb begin
    p = '0;
    for (int r = 0; r < 4; r++) begin
      if (b[r]) p = p + ({4'b0, a} << r);
    end
  end

endmodule

module matmul_seq_ctrl #(
  parameter int DIM  = 2,
  parameter int ACCW = 8 + $clog2(DIM) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIM*DIM*4-1:0]    a_flat,
  input  logic [DIM*DIM*4-1:0]    b_flat,
  output logic [DIM*DIM*ACCW-1:0] c_flat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int IW = $clog2(DIM);
  localparam logic [IW-1:0] LAST = IW'(DIM - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state;
  logic [DIM*DIM*4-1:0]    a_q;
  logic [DIM*DIM*4-1:0]    b_q;
  logic [DIM*DIM*ACCW-1:0] c_q;
  logic [ACCW-1:0]         acc;
  logic [IW-1:0]           i;
  logic [IW-1:0]           j;
  logic [IW-1:0]           k;
  logic [3:0]              op_a;
  logic [3:0]              op_b;
  logic [7:0]              prod;
  logic [ACCW-1:0]         sum;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_MUL);
  assign out_valid = (state == S_DONE);
  assign c_flat    = c_q;

  // Pick A[i][k] and B[k][j] out of the latched operands
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        if (i == IW'(r) && k == IW'(c))
          op_a = a_q[(r*DIM+c)*4 +: 4];
        if (k == IW'(r) && j == IW'(c))
          op_b = b_q[(r*DIM+c)*4 +: 4];
      end
    end
  end

  multiplier u_mul (
    .a(op_a),
    .b(op_b),
    .p(prod)
  );

  assign sum = acc + {{(ACCW-8){1'b0}}, prod};

  // Job sequencing: accept, one MAC per cycle, hold result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= a_flat;
            b_q   <= b_flat;
            c_q   <= '0;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          if (k != LAST) begin
            acc <= sum;
            k   <= k + IW'(1);
          end else begin
            for (int r = 0; r < DIM; r++) begin
              for (int c = 0; c < DIM; c++) begin
                if (i == IW'(r) && j == IW'(c))
                  c_q[(r*DIM+c)*ACCW +: ACCW] <= sum;
              end
            end
            acc <= '0;
            k   <= '0;
            if (j == LAST) begin
              j <= '0;
              if (i == LAST) begin
                i     <= '0;
                state <= S_DONE;
              end else begin
                i <= i + IW'(1);
              end
            end else begin
              j <= j + IW'(1);
            end
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencing controller that computes C = A x B for DIM x DIM matrices of 4-bit unsigned elements.
- Time-shares a single instance of the team's 4x4-bit array multiplier (`multiplier`, 8-bit product) with one registered accumulator.
- Sits between the accelerator's operand loader and result writer.
- Uses a valid/ready handshake on both the input and output sides.

Parameters:
- DIM, default 2, matrix dimension; supported values 2..4.
- ACCW, default 8+$clog2(DIM)+1, accumulator/result element width. Must be >= 8+ceil(log2(DIM)); the default gives 10 for DIM=2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  A/B operands present.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a_flat  input  DIM*DIM*4  matrix A, row-major; element [r][c] at bits [(r*DIM+c)*4 +: 4].
- b_flat  input  DIM*DIM*4  matrix B, same layout as a_flat.
- c_flat  output  DIM*DIM*ACCW  result C, row-major; element [r][c] at bits [(r*DIM+c)*ACCW +: ACCW].
- out_valid  output  1  c_flat holds a complete result.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high in MUL state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values (asynchronous, immediate):
  - State = IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - c_flat=0, accumulator=0, indices i/j/k=0.
  - Operand registers = 0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at a rising edge:
    - latch a_flat and b_flat;
    - clear c_flat and the accumulator;
    - set i=j=k=0;
    - go to MUL.
    - Without in_valid, remain in IDLE.
  - MUL: one MAC per cycle.
    - The multiplier inputs are A[i][k] and B[k][j], taken from the latched copies.
    - The product is zero-extended to ACCW.
    - If k<DIM-1: acc <= acc+prod; k++.
    - If k==DIM-1:
      - C[i][j] <= acc+prod;
      - acc <= 0; k <= 0;
      - j++ (wrap to 0 with i++).
    - After writing C[DIM-1][DIM-1], go to DONE.
  - DONE: out_valid=1.
    - c_flat is stable and in_ready=0.
    - On out_ready, go to IDLE with out_valid=0 at the next edge.
    - c_flat keeps its value until the next accept.
- Latency:
  - Operands are accepted at edge T.
  - out_valid is high after edge T+DIM^3 (8 cycles for DIM=2).
  - The earliest next accept is the edge after the out_ready handshake. There is no overlap of jobs.
- Arithmetic:
  - All values are unsigned.
  - Maximum element value is DIM*225, which must fit in ACCW; no overflow is possible with legal ACCW.
  - There is no saturation logic.
- Input side:
  - in_valid while not in IDLE is ignored. No operands are latched and the current job is unaffected.
  - a_flat and b_flat may change freely after the accept edge.
- Output side:
  - out_valid, once set, stays high until out_ready is sampled high. It is never dropped otherwise.
  - out_ready while not in DONE is ignored.
- Partial results: c_flat elements are written progressively during MUL. Consumers must only read c_flat when out_valid=1.
- Reset mid-operation (MUL or DONE): immediate return to reset values. There is no partial result and no stray out_valid.
- One multiplier instance only. No combinational path from in_valid or out_ready to any output other than through registered state.

Test Plan:
1. DIM=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], out_ready=1 -> out_valid exactly 8 cycles after accept; C=[[19,22],[43,50]]; in_ready low for the whole job.
2. A=[[15,15],[15,15]], B=[[15,15],[15,15]] -> every C element = 450, with no truncation at ACCW=10.
3. A=identity, B=[[9,0],[4,13]] -> C equals B. Hold out_ready=0 for 5 cycles after out_valid -> out_valid and c_flat stay stable and in_ready stays 0; assert out_ready -> IDLE on the next edge, out_valid=0.
4. Pulse in_valid with different operands during MUL -> ignored; result matches the first operands.
5. Assert rst at cycle 3 of MUL -> outputs immediately at reset values; next job A=[[2,0],[0,2]], B=[[3,1],[1,3]] gives [[6,2],[2,6]] with no residue from the aborted job.
6. Back-to-back jobs, in_valid held high with out_ready=1 -> second accept on the edge after DONE->IDLE; both results correct. Repeat scenario 1 with DIM=3 (27-cycle latency) and random operands against a reference model.
